// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch unit and its buffer.
package fetch_pkg;
  localparam int INSN_BYTES      = 4;
  localparam int FETCH_BUF_DEPTH = 2;
  localparam int CNT_W           = $clog2(FETCH_BUF_DEPTH + 1);

  typedef enum logic [1:0] {
    FS_ISSUE = 2'd0,
    FS_WAIT  = 2'd1,
    FS_DRAIN = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_if.sv
// Fetch unit bus bundle: instruction-memory request/response, redirect and decode-side handshake.
interface fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        ir_ready;
  logic [31:0] ir;
  logic [31:0] ir_pc;
  logic        ir_valid;

  modport master (
    output imem_req, imem_addr, ir, ir_pc, ir_valid,
    input  imem_rvalid, imem_rdata, redirect, redirect_pc, ir_ready
  );

  modport slave (
    input  imem_req, imem_addr, ir, ir_pc, ir_valid,
    output imem_rvalid, imem_rdata, redirect, redirect_pc, ir_ready
  );
endinterface

// File: rtl/fetch_buf.sv
// Small FIFO of fetched {word, pc} entries; flush takes priority over push and pop.
module fetch_buf
  import fetch_pkg::*;
(
  input  logic             clk,
  input  logic             boot,
  input  logic             push,
  input  fetch_entry_t     push_data,
  input  logic             pop,
  input  logic             flush,
  output fetch_entry_t     head,
  output logic [CNT_W-1:0] count
);
  localparam int PTR_W = (FETCH_BUF_DEPTH > 1) ? $clog2(FETCH_BUF_DEPTH) : 1;

  fetch_entry_t     mem [FETCH_BUF_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FETCH_BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_pop  = pop && (count != '0) && !flush;
  assign do_push = push && !flush && ((count != CNT_W'(FETCH_BUF_DEPTH)) || do_pop);

  always_ff @(posedge clk or negedge boot) begin
    if (!boot) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage carries no reset; emptiness is tracked by count alone.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head = (count != '0) ? mem[rd_ptr] : '0;
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding imem request, redirect handling with stale-response drain.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic      clk,
  input logic      boot,
  fetch_if.master  bus
);
  localparam logic [1:0] S_ISSUE = FS_ISSUE;
  localparam logic [1:0] S_WAIT  = FS_WAIT;
  localparam logic [1:0] S_DRAIN = FS_DRAIN;

  logic [1:0]       state;
  logic [31:0]      pc;
  logic [31:0]      req_pc;
  logic             issue;
  logic             push;
  logic             pop;
  fetch_entry_t     head;
  fetch_entry_t     push_data;
  logic [CNT_W-1:0] count;

  // Gating with boot keeps imem_req low while reset is held.
  assign issue = boot && (state == S_ISSUE) && (count < CNT_W'(FETCH_BUF_DEPTH)) && !bus.redirect;
  assign push  = (state == S_WAIT) && bus.imem_rvalid && !bus.redirect;
  assign pop   = bus.ir_valid && bus.ir_ready && !bus.redirect;

  assign push_data = '{word: bus.imem_rdata, pc: req_pc};

  assign bus.imem_req  = issue;
  assign bus.imem_addr = issue ? pc : '0;
  assign bus.ir_valid  = (count != '0);
  assign bus.ir        = head.word;
  assign bus.ir_pc     = head.pc;

  always_ff @(posedge clk or negedge boot) begin
    if (!boot) begin
      state  <= S_ISSUE;
      pc     <= RESET_PC;
      req_pc <= '0;
    end else if (bus.redirect) begin
      pc <= bus.redirect_pc;
      case (state)
        S_WAIT:  state <= bus.imem_rvalid ? S_ISSUE : S_DRAIN;
        S_DRAIN: state <= bus.imem_rvalid ? S_ISSUE : S_DRAIN;
        default: state <= S_ISSUE;
      endcase
    end else begin
      case (state)
        S_ISSUE: begin
          if (issue) begin
            req_pc <= pc;
            pc     <= pc + 32'(INSN_BYTES);
            state  <= S_WAIT;
          end
        end
        S_WAIT:  if (bus.imem_rvalid) state <= S_ISSUE;
        S_DRAIN: if (bus.imem_rvalid) state <= S_ISSUE;
        default: state <= S_ISSUE;
      endcase
    end
  end

  fetch_buf u_buf (
    .clk       (clk),
    .boot      (boot),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (bus.redirect),
    .head      (head),
    .count     (count)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: bench plays instruction memory and decode stage cycle by cycle.
module tb_fetch_unit;
  logic clk;
  logic boot;
  int   n_vec;
  int   n_err;

  fetch_if bus ();

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk  (clk),
    .boot (boot),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rv, input logic [31:0] rd, input logic rdr,
                       input logic [31:0] rpc, input logic rdy);
    bus.imem_rvalid = rv;
    bus.imem_rdata  = rd;
    bus.redirect    = rdr;
    bus.redirect_pc = rpc;
    bus.ir_ready    = rdy;
    #1;
  endtask

  task automatic chk1(input string tag, input string fld, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s.%s observed=%b expected=%b", tag, fld, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input string fld, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, fld, obs, exp);
    end
  endtask

  task automatic exp_out(input string tag, input logic req, input logic [31:0] addr,
                         input logic vld, input logic [31:0] pc, input logic [31:0] w);
    chk1 (tag, "imem_req",  bus.imem_req,  req);
    chk32(tag, "imem_addr", bus.imem_addr, addr);
    chk1 (tag, "ir_valid",  bus.ir_valid,  vld);
    chk32(tag, "ir_pc",     bus.ir_pc,     pc);
    chk32(tag, "ir",        bus.ir,        w);
  endtask

  task automatic do_reset(input string tag);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    boot = 1'b0;
    #1;
    exp_out(tag, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    tick();
    boot = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    boot  = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    tick();
    exp_out("rst0", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 32'h1234_5678, 1'b0, 32'h0, 1'b1);
    exp_out("rst1", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    tick();
    boot = 1'b1;

    // Streaming, latency 1, decode always ready
    drive(1'b0, 32'h0,         1'b0, 32'h0, 1'b1); exp_out("a0", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);          tick();
    drive(1'b1, 32'hA000_0000, 1'b0, 32'h0, 1'b1); exp_out("a1", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);          tick();
    drive(1'b0, 32'h0,         1'b0, 32'h0, 1'b1); exp_out("a2", 1'b1, 32'h4, 1'b1, 32'h0, 32'hA000_0000);  tick();
    drive(1'b1, 32'hA000_0004, 1'b0, 32'h0, 1'b1); exp_out("a3", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);          tick();
    drive(1'b0, 32'h0,         1'b0, 32'h0, 1'b1); exp_out("a4", 1'b1, 32'h8, 1'b1, 32'h4, 32'hA000_0004);  tick();
    drive(1'b1, 32'hA000_0008, 1'b0, 32'h0, 1'b1); exp_out("a5", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);          tick();
    drive(1'b0, 32'h0,         1'b0, 32'h0, 1'b1); exp_out("a6", 1'b1, 32'hC, 1'b1, 32'h8, 32'hA000_0008);  tick();

    // Decode stalled: buffer fills to two, fetch stops, then drains in order
    do_reset("rst_b");
    drive(1'b0, 32'h0,         1'b0, 32'h0, 1'b0); exp_out("b0", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);          tick();
    drive(1'b1, 32'hA000_0000, 1'b0, 32'h0, 1'b0); exp_out("b1", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);          tick();
    drive(1'b0, 32'h0,         1'b0, 32'h0, 1'b0); exp_out("b2", 1'b1, 32'h4, 1'b1, 32'h0, 32'hA000_0000);  tick();
    drive(1'b1, 32'hA000_0004, 1'b0, 32'h0, 1'b0); exp_out("b3", 1'b0, 32'h0, 1'b1, 32'h0, 32'hA000_0000);  tick();
    drive(1'b0, 32'h0,         1'b0, 32'h0, 1'b0); exp_out("b4", 1'b0, 32'h0, 1'b1, 32'h0, 32'hA000_0000);  tick();
    drive(1'b0, 32'h0,         1'b0, 32'h0, 1'b1); exp_out("b5", 1'b0, 32'h0, 1'b1, 32'h0, 32'hA000_0000);  tick();
    drive(1'b0, 32'h0,         1'b0, 32'h0, 1'b1); exp_out("b6", 1'b1, 32'h8, 1'b1, 32'h4, 32'hA000_0004);  tick();

    // Redirect while a request is outstanding: stale response is drained
    drive(1'b0, 32'h0,         1'b1, 32'h100, 1'b1); exp_out("b7", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);        tick();
    drive(1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0,   1'b1); exp_out("b8", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);        tick();
    drive(1'b0, 32'h0,         1'b0, 32'h0,   1'b1); exp_out("b9", 1'b1, 32'h100, 1'b0, 32'h0, 32'h0);      tick();
    drive(1'b1, 32'hA000_0100, 1'b0, 32'h0,   1'b1); exp_out("b10", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);       tick();
    drive(1'b0, 32'h0,         1'b0, 32'h0,   1'b1); exp_out("b11", 1'b1, 32'h104, 1'b1, 32'h100, 32'hA000_0100); tick();

    // Redirect with a full buffer and decode ready in the same cycle
    do_reset("rst_c");
    drive(1'b0, 32'h0,         1'b0, 32'h0,   1'b0); exp_out("c0", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);         tick();
    drive(1'b1, 32'hA000_0000, 1'b0, 32'h0,   1'b0); exp_out("c1", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);         tick();
    drive(1'b0, 32'h0,         1'b0, 32'h0,   1'b0); exp_out("c2", 1'b1, 32'h4, 1'b1, 32'h0, 32'hA000_0000); tick();
    drive(1'b1, 32'hA000_0004, 1'b0, 32'h0,   1'b0); exp_out("c3", 1'b0, 32'h0, 1'b1, 32'h0, 32'hA000_0000); tick();
    drive(1'b0, 32'h0,         1'b1, 32'h200, 1'b1); exp_out("c4", 1'b0, 32'h0, 1'b1, 32'h0, 32'hA000_0000); tick();
    drive(1'b0, 32'h0,         1'b0, 32'h0,   1'b1); exp_out("c5", 1'b1, 32'h200, 1'b0, 32'h0, 32'h0);       tick();

    // Reset while waiting; late response after release is ignored
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    boot = 1'b0;
    #1;
    exp_out("d_rst", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    tick();
    boot = 1'b1;
    drive(1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b1); exp_out("d1", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);          tick();
    drive(1'b1, 32'hA000_0000, 1'b0, 32'h0, 1'b1); exp_out("d2", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);          tick();
    drive(1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b1); exp_out("d3", 1'b0, 32'h0, 1'b1, 32'h0, 32'hA000_0000);  tick();

    // Address wrap past the top of the 32-bit space
    drive(1'b0, 32'h0,         1'b0, 32'h0, 1'b1); exp_out("e1", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 32'h0); tick();
    drive(1'b1, 32'h1111_2222, 1'b0, 32'h0, 1'b1); exp_out("e2", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);         tick();
    drive(1'b0, 32'h0,         1'b0, 32'h0, 1'b1); exp_out("e3", 1'b1, 32'h0, 1'b1, 32'hFFFF_FFFC, 32'h1111_2222); tick();

    // Redirect coinciding with the response: discarded, straight back to issue
    drive(1'b1, 32'hDEAD_BEEF, 1'b1, 32'h300, 1'b1); exp_out("e4", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);       tick();
    drive(1'b0, 32'h0,         1'b0, 32'h0,   1'b1); exp_out("e5", 1'b1, 32'h300, 1'b0, 32'h0, 32'h0);     tick();
    drive(1'b1, 32'hA000_0300, 1'b0, 32'h0,   1'b1); exp_out("e6", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);       tick();
    drive(1'b0, 32'h0,         1'b0, 32'h0,   1'b0); exp_out("e7", 1'b1, 32'h304, 1'b1, 32'h300, 32'hA000_0300);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
